// File: rtl/if_stage_if.sv
// IF-stage bus: instruction-memory port, redirect/stall controls from ID, and the IF/ID register outputs.
// With IF_PERF_CNT_EN defined, the fetch/kill/stall performance counters are carried as well.
interface if_stage_if;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_data;
    logic [1:0]  PCsrc;
    logic        KILL;
    logic [31:0] PC_offset;
    logic [31:0] PC_regRs;
    logic        disable_PC;
    logic        disable_IR;
    logic [31:0] PC_F;
    logic [31:0] Instruction_D;
    logic [31:0] NPC_D;
    logic        Valid_D;
`ifdef IF_PERF_CNT_EN
    logic [31:0] Fetch_cnt;
    logic [31:0] Kill_cnt;
    logic [31:0] Stall_cnt;

    modport master (
        output Imem_addr, PC_F, Instruction_D, NPC_D, Valid_D,
        output Fetch_cnt, Kill_cnt, Stall_cnt,
        input  Imem_data, PCsrc, KILL, PC_offset, PC_regRs, disable_PC, disable_IR
    );
    modport slave (
        input  Imem_addr, PC_F, Instruction_D, NPC_D, Valid_D,
        input  Fetch_cnt, Kill_cnt, Stall_cnt,
        output Imem_data, PCsrc, KILL, PC_offset, PC_regRs, disable_PC, disable_IR
    );
`else
    modport master (
        output Imem_addr, PC_F, Instruction_D, NPC_D, Valid_D,
        input  Imem_data, PCsrc, KILL, PC_offset, PC_regRs, disable_PC, disable_IR
    );
    modport slave (
        input  Imem_addr, PC_F, Instruction_D, NPC_D, Valid_D,
        output Imem_data, PCsrc, KILL, PC_offset, PC_regRs, disable_PC, disable_IR
    );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC, next-PC select, and the IF/ID pipeline register.
// Optional perf counters (fetch/kill/stall, saturating) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus
);
    logic [31:0] pc_q, pc_d, pc_inc;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    assign pc_inc = pc_q + 32'd1;

    always_comb begin
        pc_d = pc_q;
        if (!bus.disable_PC) begin
            case (bus.PCsrc)
                2'b01:   pc_d = bus.PC_offset;
                2'b10:   pc_d = bus.PC_regRs;
                default: pc_d = pc_inc;
            endcase
        end
    end

    // A killed slot still records PC+1 so NPC_D tracks the squashed fetch.
    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (!bus.disable_IR) begin
            npc_d = pc_inc;
            if (bus.KILL) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = bus.Imem_data;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            npc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Imem_addr     = pc_q;
    assign bus.PC_F          = pc_q;
    assign bus.Instruction_D = instr_q;
    assign bus.NPC_D         = npc_q;
    assign bus.Valid_D       = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.disable_IR && !bus.KILL) fetch_cnt_d = sat_inc(fetch_cnt_q);
        if (!bus.disable_IR && bus.KILL)  kill_cnt_d  = sat_inc(kill_cnt_q);
        if (bus.disable_PC)               stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Fetch_cnt = fetch_cnt_q;
    assign bus.Kill_cnt  = kill_cnt_q;
    assign bus.Stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register feeding ID_stage (Instruction_D, NPC_D).
- Consumes the redirect/kill/stall controls that ID_stage produces: PCsrc, KILL, PC_offset, PC_regRs, disable_PC, disable_IR.
- PC is word-addressed; NPC = PC + 1.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word loaded into IF/ID on reset or kill (op 0, Rp=R0, Rd=R0; R0 writes are discarded by the register file).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Imem_addr  output  32  instruction-memory word address; equals PC_F
- Imem_data  input  32  instruction word; combinational read of Imem_addr, same cycle
- PCsrc  input  2  next-PC select from ID: 00 PC+1, 01 PC_offset, 10 PC_regRs, 11 reserved (treated as 00)
- KILL  input  1  flush the instruction being fetched (taken J/CALL/JR in ID)
- PC_offset  input  32  jump/call target from ID
- PC_regRs  input  32  register-indirect target from ID
- disable_PC  input  1  hold PC (load-use stall)
- disable_IR  input  1  hold IF/ID register (load-use stall)
- PC_F  output  32  current fetch PC (register)
- Instruction_D  output  32  IF/ID instruction register
- NPC_D  output  32  IF/ID next-PC register (PC of that instruction + 1)
- Valid_D  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (synchronous, on the sampled edge): PC_F=RESET_PC, Instruction_D=NOP_INSTR, NPC_D=RESET_PC, Valid_D=0. Reset overrides every other input. Reset asserted mid-stall or mid-redirect discards pending state; no redirect survives reset.
- Imem_addr = PC_F, combinational. Fetch latency is 1 cycle: the word at PC appears in Instruction_D on the edge after PC_F=PC.
- Next PC when disable_PC=0: PCsrc 00/11 -> PC_F+1; 01 -> PC_offset; 10 -> PC_regRs.
- When disable_PC=1, PC_F holds regardless of PCsrc. Stall has priority over redirect; ID re-evaluates the branch after the stall clears.
- IF/ID update when disable_IR=0:
  - KILL=1 -> Instruction_D=NOP_INSTR, NPC_D=PC_F+1, Valid_D=0.
  - KILL=0 -> Instruction_D=Imem_data, NPC_D=PC_F+1, Valid_D=1.
- When disable_IR=1, all IF/ID fields hold, including the KILL case (stall has priority).
- disable_PC and disable_IR are honoured independently; in the normal flow they are asserted together.
- Arithmetic: PC+1 is 32-bit unsigned and wraps 32'hFFFF_FFFF -> 0 with no flag. Targets are taken verbatim with no alignment or range check.
- Redirect penalty: exactly one bubble per taken control transfer (the KILLed slot). The target instruction is in IF/ID two edges after the redirect cycle.
- No combinational path from Imem_data to any output other than through the IF/ID register.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro defined, adds three 32-bit output counters, cleared on reset, saturating at 32'hFFFF_FFFF:
  - Fetch_cnt: +1 on each edge that loads a valid instruction.
  - Kill_cnt: +1 on each edge with KILL=1 and disable_IR=0.
  - Stall_cnt: +1 on each edge with disable_PC=1.
- Without the macro, the ports and logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset + sequential fetch: RESET_PC=0; memory holds word k = 32'h1000_0000+k; release reset -> Imem_addr 0,1,2,3 on successive cycles; Instruction_D=32'h1000_0000 with NPC_D=1 one edge later; Valid_D goes 0 then 1.
- Jump redirect: at PC_F=5, assert PCsrc=01, PC_offset=32'd100, KILL=1 for one cycle -> next edge PC_F=100, Instruction_D=NOP_INSTR, Valid_D=0, NPC_D=6; following edge Instruction_D=word 100, NPC_D=101.
- Register-indirect: PCsrc=10, PC_regRs=32'd42, KILL=1 -> PC_F=42, one bubble, then word 42 with NPC_D=43.
- Load-use stall: PC_F=8, IF/ID holds word 7; assert disable_PC=disable_IR=1 for 2 cycles -> PC_F stays 8, Instruction_D stays word 7, NPC_D stays 8; on release, word 8 loads with NPC_D=9.
- Stall vs redirect collision: disable_PC=disable_IR=1 together with PCsrc=01, PC_offset=200, KILL=1 -> no PC change, IF/ID holds. Then drop the stall with the redirect still asserted -> PC_F=200, bubble inserted.
- Reset mid-redirect and wrap: reset with PCsrc=01, KILL=1 -> PC_F=RESET_PC, Valid_D=0. Separately, force PC_F=32'hFFFF_FFFF with PCsrc=00 -> PC_F=0, NPC_D=0. With IF_PERF_CNT_EN, check counter values after the stall test (Stall_cnt=2) and after the jump test (Kill_cnt=1).
